dm_store_ctrl: RTL
==================

# dm_store_ctrl

Store-side controller for the 4 KiB word-organised data memory: accepts byte, halfword and word store requests from the datapath and turns sub-word stores into a read-modify-write sequence of whole-word writes. It sits between the MEM stage and the data memory's single word write port, and complements the memory's sign-extending byte-load path. The memory read port is combinational.

## Interface
- No parameters; memory depth is fixed at 1024 words (word address 10 bits).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  store request; sampled only when ready=1
- addr  in  12  byte address of the store
- wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- size  in  2  0=byte, 1=halfword, 2=word, 3=illegal
- ready  out  1  controller idle; a request is accepted on a cycle with req=1 and ready=1
- done  out  1  one-cycle pulse in the cycle the memory write is issued
- err  out  1  one-cycle pulse for a rejected request (illegal size or misaligned)
- mem_addr  out  10  word address to memory
- mem_din  out  32  full word to write
- mem_we  out  1  memory write enable; the memory writes at the rising edge that ends the cycle
- mem_rdata  in  32  combinational read data for mem_addr

## Operation
- FSM states: IDLE, READ, WRITE, ERR.
- IDLE: ready=1. On accept, register addr, wdata and size.
  - Word with addr[1:0]=0: go to WRITE.
  - Byte, or half with addr[0]=0: go to READ.
  - Half with addr[0]=1, word with addr[1:0]≠0, or size=3: go to ERR.
- READ: drive mem_addr=addr[11:2]. At the end of the cycle, register merged = mem_rdata with the selected lane(s) replaced.
  - Byte lane is addr[1:0]: lane 0 = [7:0] … lane 3 = [31:24].
  - Half lane is addr[1]: 0 = [15:0], 1 = [31:16].
  - Go to WRITE.
- WRITE: mem_we=1, done=1, mem_din = merged for sub-word stores or wdata for word stores. Go to IDLE.
- ERR: err=1, mem_we=0. Go to IDLE.
- Unused high bits of wdata are ignored for byte and half stores.
- ready=0 in every state except IDLE. req is ignored while ready=0.

## Timing
- Accept at cycle T:
  - Word store: WRITE in T+1; memory updated at the T+1→T+2 edge; ready again at T+2.
  - Sub-word store: READ in T+1, WRITE in T+2; ready again at T+3.
  - Rejected request: err pulse at T+1; ready again at T+2.
- Maximum throughput: one word store per 2 cycles, one sub-word store per 3 cycles.
- mem_addr holds the captured word address in READ and WRITE. It is the registered value otherwise.
- mem_we, done and err are single-cycle and mutually exclusive.
- Reset values: state=IDLE, ready=1, done=0, err=0, mem_we=0, mem_addr=0, mem_din=0, capture registers=0.
- Reset asserted mid-operation (READ or WRITE) forces IDLE immediately and drops mem_we asynchronously. The pending store is lost and no partial write occurs after reset.
- A request present during reset, or in the first cycle after release, is accepted only on a clock edge where rst_n=1 and ready=1.

## Structure
- Shared package dm_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - state enum {IDLE, READ, WRITE, ERR}
  - DM_AW=10
- One combinational sub-module, st_merge: inputs old word, wdata, size, addr[1:0]; output the merged word. It is reusable by a future store buffer.
- FSM and capture registers live in dm_store_ctrl.

## Test plan
- Word store, addr=0x010, wdata=0xDEADBEEF: mem_we at T+1 with mem_addr=0x004 and mem_din=0xDEADBEEF; done at T+1; ready=1 at T+2.
- Byte store, addr=0x012, wdata=0x000000AB, memory word 4 = 0x11223344: READ at T+1; at T+2 mem_we=1 with mem_din=0x11AB3344.
- Halfword store, addr=0x006, wdata=0x0000CAFE, memory word 1 = 0xFFFFFFFF: mem_din=0xCAFEFFFF at T+2. A second half store to addr=0x004 gives final word 0xCAFECAFE.
- Misaligned half, addr=0x003: err=1 at T+1, mem_we stays 0 throughout. The same rejection applies to a size=3 request.
- Reset mid-operation: byte store accepted, rst_n pulled low during READ → mem_we never asserts, target word unchanged, ready=1 after release.
- Back-to-back: req held high for four word stores → accepts every 2 cycles; each mem_we/done pair matches its own address and data.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory store path: size encodings, FSM states,
// word-address width and the store legality rule.
package dm_pkg;

    localparam int unsigned DM_AW = 10;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        ERR   = 2'd3
    } state_e;

    // Bytes may go anywhere, halves need an even address, words need word alignment.
    function automatic logic store_legal(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            SZ_BYTE: store_legal = 1'b1;
            SZ_HALF: store_legal = (lsb[0] == 1'b0);
            SZ_WORD: store_legal = (lsb == 2'b00);
            default: store_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dm_store_ctrl_st_merge.sv
// Combinational lane merge: replaces the addressed byte/half lane of an old word
// with right-justified store data; word stores pass the data through.
module st_merge
    import dm_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  lsb,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        case (size)
            SZ_BYTE: merged[{lsb, 3'b000} +: 8]        = wdata[7:0];
            SZ_HALF: merged[{lsb[1], 4'b0000} +: 16]   = wdata[15:0];
            SZ_WORD: merged                            = wdata;
            default: merged                            = old_word;
        endcase
    end

endmodule

// File: rtl/dm_store_ctrl.sv
// Store controller: word stores write directly, sub-word stores read-modify-write
// the containing word, illegal or misaligned requests raise a one-cycle err.
module dm_store_ctrl
    import dm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [11:0]       addr,
    input  logic [31:0]       wdata,
    input  logic [1:0]        size,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [DM_AW-1:0]  mem_addr,
    output logic [31:0]       mem_din,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);

    state_e      state;
    state_e      state_nxt;
    logic        accept;
    logic [11:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [1:0]  cap_size;
    logic [31:0] data_q;
    logic [31:0] merged;

    st_merge u_merge (
        .old_word (mem_rdata),
        .wdata    (cap_wdata),
        .size     (cap_size),
        .lsb      (cap_addr[1:0]),
        .merged   (merged)
    );

    // data_q is the single write-data register: loaded with wdata on a word
    // accept, or with the merged word at the end of READ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_size  <= '0;
            data_q    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cap_addr  <= addr;
                cap_wdata <= wdata;
                cap_size  <= size;
                if (size == SZ_WORD) begin
                    data_q <= wdata;
                end
            end
            if (state == READ) begin
                data_q <= merged;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ready     = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (req) begin
                    accept = 1'b1;
                    if (!store_legal(size, addr[1:0])) begin
                        state_nxt = ERR;
                    end else if (size == SZ_WORD) begin
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            READ: begin
                state_nxt = WRITE;
            end
            WRITE: begin
                mem_we    = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            ERR: begin
                err       = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign mem_addr = cap_addr[11:2];
    assign mem_din  = data_q;

endmodule
